// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer: instruction class, entry layout and opcode decode.
// Entry field widths are fixed here; rob_unit's PREG_W/DATA_W/PC_W defaults must match them.
package rob_pkg;

    typedef enum logic [1:0] {
        TYPE_ALU   = 2'd0,
        TYPE_STORE = 2'd1,
        TYPE_LOAD  = 2'd2
    } instr_type_e;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;

    localparam int ENT_PREG_W = 6;
    localparam int ENT_DATA_W = 32;
    localparam int ENT_PC_W   = 7;

    typedef struct packed {
        logic                  valid;
        logic                  comp;
        instr_type_e           itype;
        logic [ENT_PREG_W-1:0] preg;
        logic [ENT_PREG_W-1:0] old_preg;
        logic [ENT_DATA_W-1:0] data;
        logic [ENT_PC_W-1:0]   pc;
    } rob_entry_t;

    function automatic instr_type_e decode_type(input logic [6:0] opc);
        instr_type_e t;
        case (opc)
            OPC_STORE: t = TYPE_STORE;
            OPC_LOAD:  t = TYPE_LOAD;
            default:   t = TYPE_ALU;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire window: a slot may retire only if it and every older slot in the window are ready.
module rob_retire_sel #(
    parameter int RET_W = 2,
    parameter int CNT_W = $clog2(RET_W + 1)
) (
    input  logic [RET_W-1:0] ready_i,
    output logic [RET_W-1:0] valid_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic run_s;

    // Prefix-AND over the window and count of the resulting run.
    always_comb begin
        run_s   = 1'b1;
        valid_o = '0;
        cnt_o   = '0;
        for (int j = 0; j < RET_W; j++) begin
            run_s      = run_s & ready_i[j];
            valid_o[j] = run_s;
            cnt_o      = cnt_o + CNT_W'(run_s);
        end
    end

endmodule

// File: rtl/rob_unit_chk.sv
// Protocol checks for rob_unit: contiguous dispatch lanes and completions only to pending entries.
module rob_unit_chk #(
    parameter int DISP_W = 2,
    parameter int CMPL_P = 3
) (
    input logic              clk_i,
    input logic              rst_n_i,
    input logic [DISP_W-1:0] disp_valid_i,
    input logic [CMPL_P-1:0] cmpl_bad_i
);

    a_disp_contig: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (disp_valid_i & (disp_valid_i + DISP_W'(1))) == '0);

    a_cmpl_target: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        cmpl_bad_i == '0);

endmodule

// File: rtl/rob_unit.sv
// Parametrised reorder buffer: in-order allocate, out-of-order complete by tag, in-order retire.
// Optional ROB_FLUSH_EN adds flush_i, which empties the buffer on the next edge.
module rob_unit
    import rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DISP_W = 2,
    parameter int CMPL_P = 3,
    parameter int RET_W  = 2,
    parameter int PREG_W = ENT_PREG_W,
    parameter int DATA_W = ENT_DATA_W,
    parameter int PC_W   = ENT_PC_W,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
`ifdef ROB_FLUSH_EN
    input  logic                     flush_i,
`endif
    input  logic [DISP_W-1:0]        disp_valid_i,
    output logic                     disp_ready_o,
    input  logic [DISP_W*7-1:0]      disp_opcode_i,
    input  logic [DISP_W*PREG_W-1:0] disp_preg_i,
    input  logic [DISP_W*PREG_W-1:0] disp_old_preg_i,
    input  logic [DISP_W*PC_W-1:0]   disp_pc_i,
    output logic [DISP_W*TAG_W-1:0]  disp_tag_o,
    input  logic [CMPL_P-1:0]        cmpl_valid_i,
    input  logic [CMPL_P*TAG_W-1:0]  cmpl_tag_i,
    input  logic [CMPL_P*DATA_W-1:0] cmpl_data_i,
    output logic [CMPL_P-1:0]        wake_valid_o,
    output logic [CMPL_P*PREG_W-1:0] wake_preg_o,
    output logic [CMPL_P*DATA_W-1:0] wake_data_o,
    output logic [RET_W-1:0]         ret_valid_o,
    output logic [RET_W*2-1:0]       ret_type_o,
    output logic [RET_W*PREG_W-1:0]  ret_preg_o,
    output logic [RET_W*PREG_W-1:0]  ret_old_preg_o,
    output logic [RET_W*DATA_W-1:0]  ret_data_o,
    input  logic [31:0]              total_i,
    output logic [31:0]              retired_cnt_o,
    output logic                     done_o,
    output logic [TAG_W:0]           count_o
);

    localparam int CNT_W = TAG_W + 1;
    localparam int RC_W  = $clog2(RET_W + 1);

    rob_entry_t              ent_q [DEPTH];
    rob_entry_t              ent_d [DEPTH];
    logic [TAG_W:0]          head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]          count_s, free_s, disp_cnt_s;
    logic                    disp_ready_s, flush_s;
    logic [DISP_W-1:0]       disp_fire_s;
    logic [TAG_W-1:0]        disp_idx_s [DISP_W];
    rob_entry_t              disp_ent_s [DISP_W];
    logic [TAG_W-1:0]        cmpl_tag_s [CMPL_P];
    logic [CMPL_P-1:0]       cmpl_win_s, cmpl_bad_s;
    logic [TAG_W-1:0]        ret_idx_s [RET_W];
    logic [RET_W-1:0]        ret_ready_s, ret_valid_s;
    logic [RC_W-1:0]         ret_cnt_s;
    logic [CMPL_P-1:0]       wake_valid_q, wake_valid_d;
    logic [CMPL_P*PREG_W-1:0] wake_preg_q, wake_preg_d;
    logic [CMPL_P*DATA_W-1:0] wake_data_q, wake_data_d;
    logic [31:0]             retired_cnt_q, retired_cnt_d;
    logic                    done_q, done_d;

`ifdef ROB_FLUSH_EN
    assign flush_s = flush_i;
`else
    assign flush_s = 1'b0;
`endif

    // Occupancy and dispatch credit; same-cycle retires are deliberately not counted as free.
    always_comb begin
        count_s      = tail_q - head_q;
        free_s       = CNT_W'(DEPTH) - count_s;
        disp_ready_s = (free_s >= CNT_W'(DISP_W));
        disp_fire_s  = disp_valid_i & {DISP_W{disp_ready_s & ~flush_s}};
        disp_cnt_s   = '0;
        for (int k = 0; k < DISP_W; k++) begin
            disp_idx_s[k] = tail_q[TAG_W-1:0] + TAG_W'(k);
            disp_cnt_s    = disp_cnt_s + CNT_W'(disp_fire_s[k]);
            disp_tag_o[k*TAG_W +: TAG_W] = disp_idx_s[k];
            disp_ent_s[k] = '{valid:    1'b1,
                              comp:     1'b0,
                              itype:    decode_type(disp_opcode_i[k*7 +: 7]),
                              preg:     disp_preg_i[k*PREG_W +: PREG_W],
                              old_preg: disp_old_preg_i[k*PREG_W +: PREG_W],
                              data:     {DATA_W{1'b0}},
                              pc:       disp_pc_i[k*PC_W +: PC_W]};
        end
    end

    // Completion arbitration: a pending target is required, and the lowest port wins a shared tag.
    always_comb begin
        for (int p = 0; p < CMPL_P; p++) begin
            cmpl_tag_s[p] = cmpl_tag_i[p*TAG_W +: TAG_W];
        end
        for (int p = 0; p < CMPL_P; p++) begin
            cmpl_bad_s[p] = cmpl_valid_i[p] &
                            ~(ent_q[cmpl_tag_s[p]].valid & ~ent_q[cmpl_tag_s[p]].comp);
            cmpl_win_s[p] = cmpl_valid_i[p] & ~cmpl_bad_s[p] & ~flush_s;
            for (int q = 0; q < p; q++) begin
                cmpl_win_s[p] = cmpl_win_s[p] &
                                ~(cmpl_valid_i[q] & (cmpl_tag_s[q] == cmpl_tag_s[p]));
            end
            // Only accepted completions are broadcast; losers and stray tags stay silent.
            wake_valid_d[p]                  = cmpl_win_s[p];
            wake_preg_d[p*PREG_W +: PREG_W]  = ent_q[cmpl_tag_s[p]].preg;
            wake_data_d[p*DATA_W +: DATA_W]  = cmpl_data_i[p*DATA_W +: DATA_W];
        end
    end

    // Retire window view of the oldest RET_W entries.
    always_comb begin
        for (int j = 0; j < RET_W; j++) begin
            ret_idx_s[j]   = head_q[TAG_W-1:0] + TAG_W'(j);
            ret_ready_s[j] = ent_q[ret_idx_s[j]].valid & ent_q[ret_idx_s[j]].comp & ~flush_s;
            ret_type_o[j*2 +: 2]             = ent_q[ret_idx_s[j]].itype;
            ret_preg_o[j*PREG_W +: PREG_W]   = ent_q[ret_idx_s[j]].preg;
            ret_old_preg_o[j*PREG_W +: PREG_W] = ent_q[ret_idx_s[j]].old_preg;
            ret_data_o[j*DATA_W +: DATA_W]   = ent_q[ret_idx_s[j]].data;
        end
    end

    rob_retire_sel #(
        .RET_W (RET_W),
        .CNT_W (RC_W)
    ) u_retire_sel (
        .ready_i (ret_ready_s),
        .valid_o (ret_valid_s),
        .cnt_o   (ret_cnt_s)
    );

    // Entry next-state: retire clears, completion marks, dispatch writes; targets never overlap.
    always_comb begin
        ent_d = ent_q;
        for (int j = 0; j < RET_W; j++) begin
            ent_d[ret_idx_s[j]] = ret_valid_s[j] ? rob_entry_t'('0) : ent_d[ret_idx_s[j]];
        end
        for (int p = 0; p < CMPL_P; p++) begin
            ent_d[cmpl_tag_s[p]].comp = cmpl_win_s[p] ? 1'b1 : ent_d[cmpl_tag_s[p]].comp;
            ent_d[cmpl_tag_s[p]].data = cmpl_win_s[p] ? cmpl_data_i[p*DATA_W +: DATA_W]
                                                      : ent_d[cmpl_tag_s[p]].data;
        end
        for (int k = 0; k < DISP_W; k++) begin
            ent_d[disp_idx_s[k]] = disp_fire_s[k] ? disp_ent_s[k] : ent_d[disp_idx_s[k]];
        end
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = flush_s ? rob_entry_t'('0) : ent_d[i];
        end
        head_d        = flush_s ? '0 : head_q + CNT_W'(ret_cnt_s);
        tail_d        = flush_s ? '0 : tail_q + disp_cnt_s;
        retired_cnt_d = retired_cnt_q + 32'(ret_cnt_s);
        done_d        = done_q | ((retired_cnt_d == total_i) && (total_i != 32'd0));
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            wake_valid_q  <= '0;
            wake_preg_q   <= '0;
            wake_data_q   <= '0;
            retired_cnt_q <= 32'd0;
            done_q        <= 1'b0;
        end else begin
            ent_q         <= ent_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            wake_valid_q  <= wake_valid_d;
            wake_preg_q   <= wake_preg_d;
            wake_data_q   <= wake_data_d;
            retired_cnt_q <= retired_cnt_d;
            done_q        <= done_d;
        end
    end

    assign disp_ready_o  = disp_ready_s;
    assign count_o       = count_s;
    assign ret_valid_o   = ret_valid_s;
    assign wake_valid_o  = wake_valid_q;
    assign wake_preg_o   = wake_preg_q;
    assign wake_data_o   = wake_data_q;
    assign retired_cnt_o = retired_cnt_q;
    assign done_o        = done_q;

    rob_unit_chk #(
        .DISP_W (DISP_W),
        .CMPL_P (CMPL_P)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .disp_valid_i (disp_valid_i),
        .cmpl_bad_i   (cmpl_bad_s)
    );

endmodule

// File: tb/tb_rob_unit.sv
// Scoreboard bench for rob_unit: a program-order queue model predicts wakes and retires.
module tb_rob_unit;

    localparam int DEPTH = 16, DISP_W = 2, CMPL_P = 3, RET_W = 2;
    localparam int PREG_W = 6, DATA_W = 32, PC_W = 7, TAG_W = 4;

    logic                     clk, rst_n;
    logic [DISP_W-1:0]        disp_valid_i;
    logic                     disp_ready_o;
    logic [DISP_W*7-1:0]      disp_opcode_i;
    logic [DISP_W*PREG_W-1:0] disp_preg_i, disp_old_preg_i;
    logic [DISP_W*PC_W-1:0]   disp_pc_i;
    logic [DISP_W*TAG_W-1:0]  disp_tag_o;
    logic [CMPL_P-1:0]        cmpl_valid_i, wake_valid_o;
    logic [CMPL_P*TAG_W-1:0]  cmpl_tag_i;
    logic [CMPL_P*DATA_W-1:0] cmpl_data_i, wake_data_o;
    logic [CMPL_P*PREG_W-1:0] wake_preg_o;
    logic [RET_W-1:0]         ret_valid_o;
    logic [RET_W*2-1:0]       ret_type_o;
    logic [RET_W*PREG_W-1:0]  ret_preg_o, ret_old_preg_o;
    logic [RET_W*DATA_W-1:0]  ret_data_o;
    logic [31:0]              total_i, retired_cnt_o;
    logic                     done_o;
    logic [TAG_W:0]           count_o;
`ifdef ROB_FLUSH_EN
    logic                     flush_tb;
    initial flush_tb = 1'b0;
`endif

    rob_unit dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
`ifdef ROB_FLUSH_EN
        .flush_i         (flush_tb),
`endif
        .disp_valid_i    (disp_valid_i),
        .disp_ready_o    (disp_ready_o),
        .disp_opcode_i   (disp_opcode_i),
        .disp_preg_i     (disp_preg_i),
        .disp_old_preg_i (disp_old_preg_i),
        .disp_pc_i       (disp_pc_i),
        .disp_tag_o      (disp_tag_o),
        .cmpl_valid_i    (cmpl_valid_i),
        .cmpl_tag_i      (cmpl_tag_i),
        .cmpl_data_i     (cmpl_data_i),
        .wake_valid_o    (wake_valid_o),
        .wake_preg_o     (wake_preg_o),
        .wake_data_o     (wake_data_o),
        .ret_valid_o     (ret_valid_o),
        .ret_type_o      (ret_type_o),
        .ret_preg_o      (ret_preg_o),
        .ret_old_preg_o  (ret_old_preg_o),
        .ret_data_o      (ret_data_o),
        .total_i         (total_i),
        .retired_cnt_o   (retired_cnt_o),
        .done_o          (done_o),
        .count_o         (count_o)
    );

    typedef struct {
        int                tag;
        logic [PREG_W-1:0] preg;
        logic [PREG_W-1:0] old;
        logic [1:0]        typ;
        logic [DATA_W-1:0] data;
        bit                comp;
    } op_t;
    typedef struct {
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
    } wake_t;

    op_t   m_q[$];
    op_t   exp_ret[$];
    wake_t exp_wake[$];
    int    m_tail, m_retired, m_ret_n;
    bit    m_done;
    int    total, bad;
    wake_t mon_w;
    op_t   mon_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete(); exp_ret.delete(); exp_wake.delete();
        m_tail = 0; m_retired = 0; m_ret_n = 0; m_done = 1'b0;
    endfunction

    // Applies one clock edge to the program-order model using the inputs as sampled on it.
    task automatic model_update();
        bit pre_ready;
        op_t o;
        logic [6:0] opc;
        pre_ready = (DEPTH - m_q.size()) >= DISP_W;
        for (int p = 0; p < CMPL_P; p++) begin
            if (cmpl_valid_i[p]) begin
                for (int i = 0; i < m_q.size(); i++) begin
                    if (m_q[i].tag == int'(cmpl_tag_i[p*TAG_W +: TAG_W]) && !m_q[i].comp) begin
                        o = m_q[i];
                        o.comp = 1'b1;
                        o.data = cmpl_data_i[p*DATA_W +: DATA_W];
                        m_q[i] = o;
                        exp_wake.push_back('{preg: o.preg, data: o.data});
                        break;
                    end
                end
            end
        end
        repeat (m_ret_n) void'(m_q.pop_front());
        m_retired += m_ret_n;
        if (pre_ready) begin
            for (int k = 0; k < DISP_W; k++) begin
                if (disp_valid_i[k]) begin
                    opc    = disp_opcode_i[k*7 +: 7];
                    o.tag  = m_tail;
                    o.preg = disp_preg_i[k*PREG_W +: PREG_W];
                    o.old  = disp_old_preg_i[k*PREG_W +: PREG_W];
                    o.typ  = (opc == 7'b0100011) ? 2'd1 : (opc == 7'b0000011) ? 2'd2 : 2'd0;
                    o.data = '0;
                    o.comp = 1'b0;
                    m_q.push_back(o);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
        if (total_i != 0 && m_retired == int'(total_i)) m_done = 1'b1;
        m_ret_n = 0;
        for (int j = 0; j < RET_W && j < m_q.size(); j++) begin
            if (!m_q[j].comp) break;
            exp_ret.push_back(m_q[j]);
            m_ret_n++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        #1;
        disp_valid_i = '0;
        cmpl_valid_i = '0;
    endtask

    task automatic set_disp(input int k, input logic [6:0] op, input logic [PREG_W-1:0] pr,
                            input logic [PREG_W-1:0] old);
        disp_valid_i[k] = 1'b1;
        disp_opcode_i[k*7 +: 7] = op;
        disp_preg_i[k*PREG_W +: PREG_W] = pr;
        disp_old_preg_i[k*PREG_W +: PREG_W] = old;
        disp_pc_i[k*PC_W +: PC_W] = PC_W'($urandom);
    endtask

    task automatic set_cmpl(input int p, input int tag, input logic [DATA_W-1:0] d);
        cmpl_valid_i[p] = 1'b1;
        cmpl_tag_i[p*TAG_W +: TAG_W] = TAG_W'(tag);
        cmpl_data_i[p*DATA_W +: DATA_W] = d;
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 2))
            0:       return 7'b0100011;
            1:       return 7'b0000011;
            default: return 7'b0110011;
        endcase
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_count"}, count_o, 0);
        chk({tag, "_ready"}, disp_ready_o, 1);
        chk({tag, "_ret_valid"}, ret_valid_o, 0);
        chk({tag, "_wake_valid"}, wake_valid_o, 0);
        chk({tag, "_retired"}, retired_cnt_o, 0);
        chk({tag, "_done"}, done_o, 0);
    endtask

    // Monitor: compares every presented wake/retire against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", count_o, m_q.size());
            chk("ready", disp_ready_o, (DEPTH - m_q.size()) >= DISP_W);
            chk("retired_cnt", retired_cnt_o, m_retired);
            chk("done", done_o, m_done);
            for (int k = 0; k < DISP_W; k++) chk("disp_tag", disp_tag_o[k*TAG_W +: TAG_W], (m_tail + k) % DEPTH);
            for (int p = 0; p < CMPL_P; p++) begin
                if (wake_valid_o[p]) begin
                    if (exp_wake.size() == 0) chk("wake_extra", wake_valid_o[p], 0);
                    else begin
                        mon_w = exp_wake.pop_front();
                        chk("wake_preg", wake_preg_o[p*PREG_W +: PREG_W], mon_w.preg);
                        chk("wake_data", wake_data_o[p*DATA_W +: DATA_W], mon_w.data);
                    end
                end
            end
            chk("wake_missing", exp_wake.size(), 0);
            exp_wake.delete();
            for (int j = 0; j < RET_W; j++) begin
                if (ret_valid_o[j]) begin
                    if (exp_ret.size() == 0) chk("ret_extra", ret_valid_o[j], 0);
                    else begin
                        mon_r = exp_ret.pop_front();
                        chk("ret_type", ret_type_o[j*2 +: 2], mon_r.typ);
                        chk("ret_preg", ret_preg_o[j*PREG_W +: PREG_W], mon_r.preg);
                        chk("ret_old_preg", ret_old_preg_o[j*PREG_W +: PREG_W], mon_r.old);
                        chk("ret_data", ret_data_o[j*DATA_W +: DATA_W], mon_r.data);
                    end
                end
            end
            chk("ret_missing", exp_ret.size(), 0);
            exp_ret.delete();
        end
    end

    initial begin
        int pend[$];
        int n;
        total = 0; bad = 0;
        model_reset();
        rst_n = 1'b0; total_i = 32'd4;
        disp_valid_i = '0; disp_opcode_i = '0; disp_preg_i = '0; disp_old_preg_i = '0;
        disp_pc_i = '0; cmpl_valid_i = '0; cmpl_tag_i = '0; cmpl_data_i = '0;
        #3;
        reset_checks("reset");
        #9 rst_n = 1'b1;

        // Two ALU ops, both completed in one cycle.
        set_disp(0, 7'b0110011, 6'd33, 6'd1);
        set_disp(1, 7'b0110011, 6'd34, 6'd2);
        tick();
        set_cmpl(0, 0, 32'd5);
        set_cmpl(1, 1, 32'd7);
        tick();
        chk("t1_wake_valid", wake_valid_o, 3'b011);
        chk("t1_wake_data0", wake_data_o[31:0], 32'd5);
        chk("t1_ret_valid", ret_valid_o, 2'b11);
        tick();
        chk("t1_count", count_o, 0);
        chk("t1_retired", retired_cnt_o, 2);

        // Younger completes first: nothing retires until the older one completes.
        set_disp(0, 7'b0100011, 6'd10, 6'd3);
        set_disp(1, 7'b0000011, 6'd11, 6'd4);
        tick();
        set_cmpl(0, 3, 32'd100);
        tick();
        chk("t2_hold_a", ret_valid_o, 2'b00);
        tick();
        chk("t2_hold_b", ret_valid_o, 2'b00);
        set_cmpl(2, 2, 32'd200);
        tick();
        chk("t2_both", ret_valid_o, 2'b11);
        tick();
        chk("t2_retired", retired_cnt_o, 4);
        chk("t2_done", done_o, 1);

        // Two ports hit the same tag: the lower port's data is kept.
        set_disp(0, 7'b0110011, 6'd20, 6'd5);
        set_disp(1, 7'b0110011, 6'd21, 6'd6);
        tick();
        set_cmpl(0, 5, 32'd9);
        set_cmpl(1, 5, 32'd4);
        set_cmpl(2, 4, 32'd1);
        tick();
        chk("dup_wake_valid", wake_valid_o, 3'b101);
        chk("dup_ret_data", ret_data_o[DATA_W +: DATA_W], 32'd9);
        tick();
        chk("done_sticky", done_o, 1);

        // Fill to capacity across the pointer wrap.
        for (int c = 0; c < 8; c++) begin
            set_disp(0, pick_op(), PREG_W'($urandom), PREG_W'($urandom));
            set_disp(1, pick_op(), PREG_W'($urandom), PREG_W'($urandom));
            tick();
        end
        chk("full_count", count_o, 16);
        chk("full_ready", disp_ready_o, 0);
        set_cmpl(0, m_q[0].tag, 32'h11);
        tick();
        tick();
        chk("c15_count", count_o, 15);
        chk("c15_ready", disp_ready_o, 0);
        set_cmpl(1, m_q[0].tag, 32'h22);
        tick();
        tick();
        chk("c14_ready", disp_ready_o, 1);

        // Randomised traffic with an asynchronous reset in the middle.
        for (int c = 0; c < 300; c++) begin
            if (c == 150) begin
                #2 rst_n = 1'b0;
                #1 reset_checks("midreset");
                model_reset();
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            n = (c % 40 < 20) ? $urandom_range(1, DISP_W) : $urandom_range(0, DISP_W);
            for (int k = 0; k < n; k++) set_disp(k, pick_op(), PREG_W'($urandom), PREG_W'($urandom));
            pend.delete();
            foreach (m_q[i]) if (!m_q[i].comp) pend.push_back(m_q[i].tag);
            for (int p = 0; p < CMPL_P; p++) begin
                if (pend.size() > 0 && $urandom_range(0, 2) == 0)
                    set_cmpl(p, pend[$urandom_range(0, pend.size() - 1)], $urandom);
            end
            tick();
        end

        // Drain everything still in flight.
        for (int c = 0; c < 200 && m_q.size() > 0; c++) begin
            pend.delete();
            foreach (m_q[i]) if (!m_q[i].comp) pend.push_back(m_q[i].tag);
            for (int p = 0; p < CMPL_P && p < pend.size(); p++) set_cmpl(p, pend[p], $urandom);
            tick();
        end
        tick();
        chk("drain_count", count_o, 0);
        chk("drain_done", done_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
